wb_stage_mc: RTL and testbench

Multi-channel writeback stage that succeeds the single-channel writeback. It merges the in-order pipeline result (channel 0) with NUM_CH-1 long-latency result channels (divider, CSR unit, miss return) onto a single register-file write port. Each channel is buffered in its own small FIFO; arbitration gives channel 0 strict priority and round-robins the others. The block drives the register file and the forwarding network, and supports stall and per-channel flush.

---
 rtl/wb_stage_mc_pkg.sv | 36 +++
 rtl/wb_stage_mc_if.sv | 55 +++++
 rtl/wb_chan_fifo.sv | 71 +++++++
 rtl/wb_stage_mc.sv | 143 ++++++++++++++
 tb/tb_wb_stage_mc.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_mc_pkg.sv
// ============================================================================
// Module      : wb_stage_mc_pkg
// Description : Shared types and constants for the multi-channel writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_stage_mc_pkg;

    typedef enum logic [1:0] {
        ALU       = 2'd0,
        MEM       = 2'd1,
        CSR       = 2'd2,
        PC_PLUS_4 = 2'd3
    } wb_src_t;

    localparam int CH_PIPE   = 0;
    localparam int FWD_XLEN  = 32;
    localparam int FWD_REG_W = 5;
    localparam int FWD_CH_W  = 4;

    typedef struct packed {
        logic                 valid;
        logic [FWD_REG_W-1:0] rd;
        logic [FWD_XLEN-1:0]  rd_data;
        logic [FWD_CH_W-1:0]  ch;
    } wb_fwd_t;

    // Round-robin successor over the side channels 1..num_ch-1.
    function automatic int unsigned rr_after(int unsigned ch, int unsigned num_ch);
        return (ch >= num_ch - 1) ? 1 : ch + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_stage_mc_if.sv
// ============================================================================
// Module      : wb_stage_mc_if
// Description : Result-channel, register-file and forwarding bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_stage_mc_if
    import wb_stage_mc_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DEPTH  = 2,
    parameter int XLEN   = 32,
    parameter int REG_W  = 5
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_src_t                         ch0_wr_src_i;
    logic [XLEN-1:0]                 ch0_alu_i;
    logic [XLEN-1:0]                 ch0_mem_i;
    logic [XLEN-1:0]                 ch0_csr_i;
    logic [XLEN-1:0]                 ch0_pc4_i;
    logic [NUM_CH-1:0]               ch_valid_i;
    logic [NUM_CH-1:0]               ch_ready_o;
    logic [NUM_CH-1:0]               ch_wr_en_i;
    logic [NUM_CH-1:0][REG_W-1:0]    ch_rd_i;
    logic [NUM_CH-2:0][XLEN-1:0]     ch_data_i;
    logic                            stall_i;
    logic                            flush_i;
    logic [NUM_CH-1:0]               flush_mask_i;
    logic                            rf_wr_en_o;
    logic [REG_W-1:0]                rf_wr_reg_o;
    logic [XLEN-1:0]                 rf_wr_data_o;
    wb_fwd_t                         data_fwd_o;
    logic [NUM_CH-1:0][CNT_W-1:0]    ch_count_o;

    modport master (
        output ch0_wr_src_i, ch0_alu_i, ch0_mem_i, ch0_csr_i, ch0_pc4_i,
        output ch_valid_i, ch_wr_en_i, ch_rd_i, ch_data_i,
        output stall_i, flush_i, flush_mask_i,
        input  ch_ready_o, rf_wr_en_o, rf_wr_reg_o, rf_wr_data_o,
        input  data_fwd_o, ch_count_o
    );

    modport slave (
        input  ch0_wr_src_i, ch0_alu_i, ch0_mem_i, ch0_csr_i, ch0_pc4_i,
        input  ch_valid_i, ch_wr_en_i, ch_rd_i, ch_data_i,
        input  stall_i, flush_i, flush_mask_i,
        output ch_ready_o, rf_wr_en_o, rf_wr_reg_o, rf_wr_data_o,
        output data_fwd_o, ch_count_o
    );

endinterface

`default_nettype wire

// File: rtl/wb_chan_fifo.sv
// ============================================================================
// Module      : wb_chan_fifo
// Description : Per-channel result FIFO holding {rd, data}, with flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_chan_fifo #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32,
    parameter int REG_W = 5
) (
    input  wire logic                       clk_i,
    input  wire logic                       rst_ni,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire logic                       flush,
    input  wire logic [REG_W-1:0]           push_rd,
    input  wire logic [XLEN-1:0]            push_data,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            empty,
    output logic                            full,
    output logic [REG_W-1:0]                head_rd,
    output logic [XLEN-1:0]                 head_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [REG_W-1:0] mem_rd   [DEPTH];
    logic [XLEN-1:0]  mem_data [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full      = (cnt == CNT_W'(DEPTH));
    assign empty     = (cnt == '0);
    assign do_push   = push && !flush && !full;
    assign do_pop    = pop && !flush && !empty;
    assign count     = cnt;
    assign head_rd   = mem_rd[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries no reset: an entry is only read while count covers it.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_rd[wr_ptr]   <= push_rd;
            mem_data[wr_ptr] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_stage_mc.sv
// ============================================================================
// Module      : wb_stage_mc
// Description : Multi-channel writeback: per-channel FIFOs merged onto one
//               register-file write port, ch0 strict priority, others RR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage_mc
    import wb_stage_mc_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DEPTH  = 2,
    parameter int XLEN   = 32,
    parameter int REG_W  = 5
) (
    input  wire logic      clk_i,
    input  wire logic      rst_ni,
    wb_stage_mc_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CH_W  = $clog2(NUM_CH);

    logic [XLEN-1:0]   ch0_data;
    logic [NUM_CH-1:0] flushed;
    logic [NUM_CH-1:0] push_fire;
    logic [NUM_CH-1:0] store;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] eligible;
    logic [XLEN-1:0]   push_data [NUM_CH];
    logic [REG_W-1:0]  head_rd   [NUM_CH];
    logic [XLEN-1:0]   head_data [NUM_CH];
    logic [CNT_W-1:0]  count     [NUM_CH];
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_valid;

    always_comb begin
        ch0_data = '0;
        case (bus.ch0_wr_src_i)
            ALU:       ch0_data = bus.ch0_alu_i;
            MEM:       ch0_data = bus.ch0_mem_i;
            CSR:       ch0_data = bus.ch0_csr_i;
            PC_PLUS_4: ch0_data = bus.ch0_pc4_i;
            default:   ch0_data = '0;
        endcase
    end

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
            assign flushed[c]   = bus.flush_i && bus.flush_mask_i[c];
            assign push_fire[c] = bus.ch_valid_i[c] && bus.ch_ready_o[c] && !flushed[c];
            // Results that write nothing complete the handshake without a slot.
            assign store[c]     = push_fire[c] && bus.ch_wr_en_i[c] && (bus.ch_rd_i[c] != '0);
            assign eligible[c]  = !empty[c] && !flushed[c];

            if (c == CH_PIPE) begin : g_pipe
                assign push_data[c] = ch0_data;
            end else begin : g_side
                assign push_data[c] = bus.ch_data_i[c-1];
            end

            wb_chan_fifo #(
                .DEPTH (DEPTH),
                .XLEN  (XLEN),
                .REG_W (REG_W)
            ) u_fifo (
                .clk_i     (clk_i),
                .rst_ni    (rst_ni),
                .push      (store[c]),
                .pop       (pop[c]),
                .flush     (flushed[c]),
                .push_rd   (bus.ch_rd_i[c]),
                .push_data (push_data[c]),
                .count     (count[c]),
                .empty     (empty[c]),
                .full      (full[c]),
                .head_rd   (head_rd[c]),
                .head_data (head_data[c])
            );
        end
    endgenerate

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            bus.ch_ready_o[c] = rst_ni && !full[c];
            bus.ch_count_o[c] = count[c];
        end
    end

    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (!bus.stall_i) begin
            if (eligible[CH_PIPE]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'(CH_PIPE);
            end else begin
                for (int k = 0; k < NUM_CH - 1; k++) begin
                    idx = ((int'(rr_ptr) - 1 + k) % (NUM_CH - 1)) + 1;
                    if (!grant_valid && eligible[idx]) begin
                        grant_valid = 1'b1;
                        grant_idx   = CH_W'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        if (grant_valid) pop[grant_idx] = 1'b1;
    end

    always_comb begin
        bus.rf_wr_en_o   = grant_valid;
        bus.rf_wr_reg_o  = grant_valid ? head_rd[grant_idx]   : '0;
        bus.rf_wr_data_o = grant_valid ? head_data[grant_idx] : '0;
        bus.data_fwd_o   = '0;
        if (grant_valid) begin
            bus.data_fwd_o.valid   = 1'b1;
            bus.data_fwd_o.rd      = FWD_REG_W'(head_rd[grant_idx]);
            bus.data_fwd_o.rd_data = FWD_XLEN'(head_data[grant_idx]);
            bus.data_fwd_o.ch      = FWD_CH_W'(grant_idx);
        end
    end

    // Pipe grants leave the side-channel rotation untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= CH_W'(1);
        end else if (grant_valid && (grant_idx != CH_W'(CH_PIPE))) begin
            rr_ptr <= CH_W'(rr_after(32'(grant_idx), NUM_CH));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_stage_mc.sv
// ============================================================================
// Module      : tb_wb_stage_mc
// Description : Self-checking bench for wb_stage_mc against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_stage_mc;
    import wb_stage_mc_pkg::*;

    localparam int NUM_CH = 3;
    localparam int DEPTH  = 2;
    localparam int XLEN   = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 2;

    logic clk    = 1'b0;
    logic rst_ni = 1'b1;
    always #5 clk = ~clk;

    wb_stage_mc_if #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .XLEN(XLEN), .REG_W(REG_W)) bus ();

    wb_stage_mc #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .XLEN(XLEN), .REG_W(REG_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Model: each channel is a queue of {rd, data}; rr names the side channel served first.
    logic [REG_W+XLEN-1:0] mq [NUM_CH][$];
    int                    rr = 1;

    logic              exp_wr;
    int                exp_ch;
    logic [REG_W-1:0]  exp_reg;
    logic [XLEN-1:0]   exp_data;
    wb_fwd_t           exp_fwd;
    logic [NUM_CH-1:0] exp_ready;

    task automatic clear_inputs();
        bus.ch0_wr_src_i = ALU;
        bus.ch0_alu_i    = '0;
        bus.ch0_mem_i    = '0;
        bus.ch0_csr_i    = '0;
        bus.ch0_pc4_i    = '0;
        bus.ch_valid_i   = '0;
        bus.ch_wr_en_i   = '0;
        bus.ch_rd_i      = '0;
        bus.ch_data_i    = '0;
        bus.stall_i      = 1'b0;
        bus.flush_i      = 1'b0;
        bus.flush_mask_i = '0;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) mq[c].delete();
        rr = 1;
    endtask

    function automatic bit masked(int c);
        return bus.flush_i && bus.flush_mask_i[c];
    endfunction

    function automatic logic [XLEN-1:0] cdata(int c);
        if (c != 0) return bus.ch_data_i[c-1];
        case (bus.ch0_wr_src_i)
            ALU:       return bus.ch0_alu_i;
            MEM:       return bus.ch0_mem_i;
            CSR:       return bus.ch0_csr_i;
            PC_PLUS_4: return bus.ch0_pc4_i;
            default:   return '0;
        endcase
    endfunction

    // Writer this cycle: the pipe if it has work, else the first side channel with work at or after rr.
    task automatic predict();
        exp_wr = 1'b0; exp_ch = 0; exp_reg = '0; exp_data = '0; exp_fwd = '0;
        for (int c = 0; c < NUM_CH; c++) exp_ready[c] = (mq[c].size() < DEPTH);
        if (!bus.stall_i) begin
            if (mq[0].size() > 0 && !masked(0)) begin
                exp_wr = 1'b1; exp_ch = 0;
            end else begin
                int order [$];
                for (int c = rr; c < NUM_CH; c++) order.push_back(c);
                for (int c = 1; c < rr; c++) order.push_back(c);
                foreach (order[i]) begin
                    if (!exp_wr && mq[order[i]].size() > 0 && !masked(order[i])) begin
                        exp_wr = 1'b1; exp_ch = order[i];
                    end
                end
            end
        end
        if (exp_wr) begin
            {exp_reg, exp_data} = mq[exp_ch][0];
            exp_fwd.valid   = 1'b1;
            exp_fwd.rd      = exp_reg;
            exp_fwd.rd_data = exp_data;
            exp_fwd.ch      = 4'(exp_ch);
        end
    endtask

    task automatic commit();
        @(posedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
            bit had_room;
            had_room = (mq[c].size() < DEPTH);
            if (masked(c)) begin
                mq[c].delete();
            end else begin
                if (exp_wr && exp_ch == c) void'(mq[c].pop_front());
                if (bus.ch_valid_i[c] && had_room && bus.ch_wr_en_i[c] && bus.ch_rd_i[c] != '0)
                    mq[c].push_back({bus.ch_rd_i[c], cdata(c)});
            end
        end
        if (exp_wr && exp_ch != 0) rr = (exp_ch == NUM_CH - 1) ? 1 : exp_ch + 1;
    endtask

    task automatic start();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic settle();
        #1;
        predict();
    endtask

    function automatic int model_fill();
        int n = 0;
        for (int c = 0; c < NUM_CH; c++) n += mq[c].size();
        return n;
    endfunction

    task automatic drain();
        int n = 0;
        while (model_fill() > 0 && n < 20) begin
            start(); settle(); commit(); n++;
        end
        total++;
        if (model_fill() != 0) begin bad++; $display("FAIL drain_timeout left=%0d exp=0", model_fill()); end
    endtask

    task automatic test_reset();
        clear_inputs();
        #1 rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (bus.ch_ready_o !== 3'b000) begin bad++; $display("FAIL rst_ready got=%b exp=000", bus.ch_ready_o); end
        total++; if (bus.rf_wr_en_o !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b exp=0", bus.rf_wr_en_o); end
        total++; if (bus.data_fwd_o !== '0) begin bad++; $display("FAIL rst_fwd got=%h exp=0", bus.data_fwd_o); end
        rst_ni = 1'b1;
        model_reset();
        #1;
        total++; if (bus.ch_ready_o !== 3'b111) begin bad++; $display("FAIL rel_ready got=%b exp=111", bus.ch_ready_o); end
        total++; if (bus.ch_count_o !== '0) begin bad++; $display("FAIL rel_count got=%h exp=0", bus.ch_count_o); end
        total++; if (bus.rf_wr_reg_o !== '0 || bus.rf_wr_data_o !== '0) begin
            bad++; $display("FAIL rel_rf got=%h/%h exp=0/0", bus.rf_wr_reg_o, bus.rf_wr_data_o); end
    endtask

    task automatic test_ch0_basic();
        start();
        bus.ch_valid_i[0] = 1'b1; bus.ch_wr_en_i[0] = 1'b1; bus.ch_rd_i[0] = 5'd5;
        bus.ch0_wr_src_i = ALU; bus.ch0_alu_i = 32'h11; bus.ch0_mem_i = 32'hDEAD;
        settle();
        total++; if (bus.rf_wr_en_o !== 1'b0) begin bad++; $display("FAIL ch0_no_bypass got=%b exp=0", bus.rf_wr_en_o); end
        commit();
        start(); settle();
        total++; if (bus.rf_wr_en_o !== 1'b1 || bus.rf_wr_reg_o !== 5'd5 || bus.rf_wr_data_o !== 32'h11) begin
            bad++; $display("FAIL ch0_write got=%b/%0d/%h exp=1/5/11", bus.rf_wr_en_o, bus.rf_wr_reg_o, bus.rf_wr_data_o); end
        total++; if (bus.data_fwd_o.valid !== 1'b1 || bus.data_fwd_o.ch !== 4'd0) begin
            bad++; $display("FAIL ch0_fwd got=%b/%0d exp=1/0", bus.data_fwd_o.valid, bus.data_fwd_o.ch); end
        commit();
    endtask

    task automatic test_priority();
        start();
        bus.ch_valid_i = 3'b011; bus.ch_wr_en_i = 3'b011;
        bus.ch_rd_i[0] = 5'd3; bus.ch0_wr_src_i = CSR; bus.ch0_csr_i = 32'hC5; bus.ch0_alu_i = 32'h77;
        bus.ch_rd_i[1] = 5'd7; bus.ch_data_i[0] = 32'hAA;
        settle(); commit();
        start(); settle();
        total++; if (bus.rf_wr_reg_o !== 5'd3 || bus.rf_wr_data_o !== 32'hC5 || bus.data_fwd_o.ch !== 4'd0) begin
            bad++; $display("FAIL prio_first got=%0d/%h/ch%0d exp=3/c5/ch0", bus.rf_wr_reg_o, bus.rf_wr_data_o, bus.data_fwd_o.ch); end
        commit();
        start(); settle();
        total++; if (bus.rf_wr_reg_o !== 5'd7 || bus.rf_wr_data_o !== 32'hAA || bus.data_fwd_o.ch !== 4'd1) begin
            bad++; $display("FAIL prio_second got=%0d/%h/ch%0d exp=7/aa/ch1", bus.rf_wr_reg_o, bus.rf_wr_data_o, bus.data_fwd_o.ch); end
        commit();
        start(); settle();
        total++; if (bus.rf_wr_en_o !== 1'b0) begin bad++; $display("FAIL prio_idle got=%b exp=0", bus.rf_wr_en_o); end
        commit();
    endtask

    task automatic push_side(input bit stall);
        bus.stall_i = stall;
        bus.ch_valid_i = 3'b110; bus.ch_wr_en_i = 3'b110;
        bus.ch_rd_i[1] = 5'($urandom_range(1, 31)); bus.ch_data_i[0] = $urandom;
        bus.ch_rd_i[2] = 5'($urandom_range(1, 31)); bus.ch_data_i[1] = $urandom;
    endtask

    task automatic test_round_robin();
        int prev = -1;
        repeat (2) begin start(); push_side(1'b1); settle(); commit(); end
        for (int k = 0; k < 6; k++) begin
            start(); push_side(1'b0); settle();
            total++; if (bus.rf_wr_en_o !== 1'b1 || int'(bus.data_fwd_o.ch) != exp_ch || bus.rf_wr_data_o !== exp_data) begin
                bad++; $display("FAIL rr_grant k=%0d got=ch%0d/%h exp=ch%0d/%h", k, bus.data_fwd_o.ch, bus.rf_wr_data_o, exp_ch, exp_data); end
            if (k > 0) begin
                total++; if (int'(bus.data_fwd_o.ch) == prev || bus.data_fwd_o.ch == 4'd0) begin
                    bad++; $display("FAIL rr_alternate k=%0d got=ch%0d exp=not ch%0d", k, bus.data_fwd_o.ch, prev); end
            end
            prev = int'(bus.data_fwd_o.ch);
            commit();
        end
        drain();
    endtask

    task automatic test_stall_full();
        for (int k = 0; k < 2; k++) begin
            start(); bus.stall_i = 1'b1;
            bus.ch_valid_i[2] = 1'b1; bus.ch_wr_en_i[2] = 1'b1;
            bus.ch_rd_i[2] = 5'(20 + k); bus.ch_data_i[1] = 32'h200 + k;
            settle(); commit();
        end
        start(); bus.stall_i = 1'b1; settle();
        total++; if (bus.ch_ready_o[2] !== 1'b0 || bus.ch_count_o[2] !== 2'd2 || bus.rf_wr_en_o !== 1'b0) begin
            bad++; $display("FAIL full_stall got=rdy%b/cnt%0d/wr%b exp=rdy0/cnt2/wr0", bus.ch_ready_o[2], bus.ch_count_o[2], bus.rf_wr_en_o); end
        commit();
        start(); settle();
        total++; if (bus.rf_wr_en_o !== 1'b1 || bus.rf_wr_data_o !== 32'h200 || bus.ch_ready_o[2] !== 1'b0) begin
            bad++; $display("FAIL unstall_1 got=wr%b/%h/rdy%b exp=wr1/200/rdy0", bus.rf_wr_en_o, bus.rf_wr_data_o, bus.ch_ready_o[2]); end
        commit();
        start(); settle();
        total++; if (bus.rf_wr_en_o !== 1'b1 || bus.rf_wr_data_o !== 32'h201 || bus.ch_ready_o[2] !== 1'b1) begin
            bad++; $display("FAIL unstall_2 got=wr%b/%h/rdy%b exp=wr1/201/rdy1", bus.rf_wr_en_o, bus.rf_wr_data_o, bus.ch_ready_o[2]); end
        commit();
        start(); settle();
        total++; if (bus.rf_wr_en_o !== 1'b0) begin bad++; $display("FAIL unstall_idle got=%b exp=0", bus.rf_wr_en_o); end
        commit();
    endtask

    task automatic test_flush();
        for (int k = 0; k < 2; k++) begin
            start(); bus.stall_i = 1'b1;
            bus.ch_valid_i[1] = 1'b1; bus.ch_wr_en_i[1] = 1'b1;
            bus.ch_rd_i[1] = 5'(10 + k); bus.ch_data_i[0] = 32'h100 + k;
            settle(); commit();
        end
        start();
        bus.flush_i = 1'b1; bus.flush_mask_i = 3'b010;
        bus.ch_valid_i[0] = 1'b1; bus.ch_wr_en_i[0] = 1'b1; bus.ch_rd_i[0] = 5'd9; bus.ch0_alu_i = 32'h99;
        settle();
        total++; if (bus.rf_wr_en_o !== 1'b0) begin bad++; $display("FAIL flush_cycle_wr got=%b exp=0", bus.rf_wr_en_o); end
        commit();
        start(); settle();
        total++; if (bus.ch_count_o[1] !== 2'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", bus.ch_count_o[1]); end
        total++; if (bus.rf_wr_en_o !== 1'b1 || bus.rf_wr_reg_o !== 5'd9 || bus.rf_wr_data_o !== 32'h99) begin
            bad++; $display("FAIL flush_ch0 got=%b/%0d/%h exp=1/9/99", bus.rf_wr_en_o, bus.rf_wr_reg_o, bus.rf_wr_data_o); end
        commit();
        start(); settle();
        total++; if (bus.rf_wr_en_o !== 1'b0) begin bad++; $display("FAIL flush_after got=%b exp=0", bus.rf_wr_en_o); end
        commit();
    endtask

    task automatic test_discard();
        start();
        bus.ch_valid_i[1] = 1'b1; bus.ch_wr_en_i[1] = 1'b1; bus.ch_rd_i[1] = 5'd0; bus.ch_data_i[0] = 32'h55;
        settle();
        total++; if (bus.ch_ready_o[1] !== 1'b1) begin bad++; $display("FAIL disc_ready got=%b exp=1", bus.ch_ready_o[1]); end
        commit();
        start();
        bus.ch_valid_i[1] = 1'b1; bus.ch_wr_en_i[1] = 1'b0; bus.ch_rd_i[1] = 5'd4; bus.ch_data_i[0] = 32'h66;
        settle();
        total++; if (bus.ch_count_o[1] !== 2'd0 || bus.rf_wr_en_o !== 1'b0) begin
            bad++; $display("FAIL disc_rd0 got=cnt%0d/wr%b exp=cnt0/wr0", bus.ch_count_o[1], bus.rf_wr_en_o); end
        commit();
        start(); settle();
        total++; if (bus.ch_count_o[1] !== 2'd0 || bus.rf_wr_en_o !== 1'b0) begin
            bad++; $display("FAIL disc_noen got=cnt%0d/wr%b exp=cnt0/wr0", bus.ch_count_o[1], bus.rf_wr_en_o); end
        commit();
    endtask

    task automatic test_random(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            start();
            for (int c = 0; c < NUM_CH; c++) begin
                bus.ch_valid_i[c] = 1'($urandom_range(0, 1));
                bus.ch_wr_en_i[c] = ($urandom_range(0, 7) != 0);
                bus.ch_rd_i[c]    = 5'($urandom_range(0, 31));
            end
            bus.ch_data_i    = {$urandom, $urandom};
            bus.ch0_wr_src_i = wb_src_t'($urandom_range(0, 3));
            bus.ch0_alu_i = $urandom; bus.ch0_mem_i = $urandom;
            bus.ch0_csr_i = $urandom; bus.ch0_pc4_i = $urandom;
            bus.stall_i      = ($urandom_range(0, 3) == 0);
            bus.flush_i      = ($urandom_range(0, 9) == 0);
            bus.flush_mask_i = 3'($urandom_range(0, 7));
            settle();
            total++; if (bus.rf_wr_en_o !== exp_wr || bus.rf_wr_reg_o !== exp_reg || bus.rf_wr_data_o !== exp_data) begin
                bad++; $display("FAIL rand_rf n=%0d got=%b/%0d/%h exp=%b/%0d/%h", n, bus.rf_wr_en_o, bus.rf_wr_reg_o,
                                bus.rf_wr_data_o, exp_wr, exp_reg, exp_data); end
            total++; if (bus.data_fwd_o !== exp_fwd) begin
                bad++; $display("FAIL rand_fwd n=%0d got=%h exp=%h", n, bus.data_fwd_o, exp_fwd); end
            total++; if (bus.ch_ready_o !== exp_ready) begin
                bad++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, bus.ch_ready_o, exp_ready); end
            for (int c = 0; c < NUM_CH; c++) begin
                total++; if (bus.ch_count_o[c] !== CNT_W'(mq[c].size())) begin
                    bad++; $display("FAIL rand_count n=%0d ch=%0d got=%0d exp=%0d", n, c, bus.ch_count_o[c], mq[c].size()); end
            end
            commit();
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            start(); bus.stall_i = 1'b1;
            bus.ch_valid_i = 3'b111; bus.ch_wr_en_i = 3'b111;
            bus.ch_rd_i = {5'd30, 5'd29, 5'(28 - k)}; bus.ch_data_i = {$urandom, $urandom}; bus.ch0_alu_i = $urandom;
            settle(); commit();
        end
        start(); settle();
        total++; if (bus.ch_count_o !== {2'd2, 2'd2, 2'd2} || bus.rf_wr_en_o !== 1'b1) begin
            bad++; $display("FAIL mid_full got=cnt%h/wr%b exp=cnt2a/wr1", bus.ch_count_o, bus.rf_wr_en_o); end
        #2 rst_ni = 1'b0;
        #1;
        total++; if (bus.rf_wr_en_o !== 1'b0 || bus.data_fwd_o !== '0 || bus.rf_wr_data_o !== '0) begin
            bad++; $display("FAIL mid_rst_out got=%b/%h exp=0/0", bus.rf_wr_en_o, bus.data_fwd_o); end
        total++; if (bus.ch_count_o !== '0 || bus.ch_ready_o !== 3'b000) begin
            bad++; $display("FAIL mid_rst_state got=cnt%h/rdy%b exp=0/000", bus.ch_count_o, bus.ch_ready_o); end
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_ch0_basic();
        test_priority();
        test_round_robin();
        test_stall_full();
        test_flush();
        test_discard();
        test_random(400);
        test_reset_mid();
        test_random(100);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
